// File: rtl/fifo_ctrl.sv
// fifo_ctrl: round-robin write arbiter for three byte requesters in front of a FIFO,
// plus a two-entry prefetch buffer that turns FIFO reads into a valid/ready stream.
module fifo_ctrl #(
    parameter int unsigned AFULL_LEVEL = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req_valid,
    input  logic [23:0] req_data,
    output logic [2:0]  req_ready,
    output logic        fifo_wr_en,
    output logic [7:0]  fifo_data_in,
    input  logic        fifo_full,
    output logic        fifo_rd_en,
    input  logic [7:0]  fifo_data_out,
    input  logic        fifo_empty,
    input  logic [3:0]  fifo_words,
    output logic        m_valid,
    output logic [7:0]  m_data,
    input  logic        m_ready,
    output logic [1:0]  grant_id,
    output logic        almost_full
);

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned SUM_W   = 3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_e;

    // Reduce a requester index in 0..2*NUM_REQ-2 back into 0..NUM_REQ-1.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [SUM_W-1:0] x);
        logic [PTR_W-1:0] r;
        if (x >= SUM_W'(NUM_REQ)) begin
            r = PTR_W'(x - SUM_W'(NUM_REQ));
        end else begin
            r = PTR_W'(x);
        end
        return r;
    endfunction

    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  ptr_d;
    logic [PTR_W-1:0]  grant_id_q;
    logic [PTR_W-1:0]  grant_id_d;
    logic              req_hit_c;
    logic [PTR_W-1:0]  grant_idx_c;
    logic              grant_c;

    occ_e              state_q;
    occ_e              state_d;
    logic              inflight_q;
    logic              inflight_d;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] head_d;
    logic [DATA_W-1:0] tail_q;
    logic [DATA_W-1:0] tail_d;
    logic              pop_c;
    logic              capture_c;
    logic [SUM_W-1:0]  pending_c;

    // Search upward from ptr; idle requesters are passed over without using a turn.
    always_comb begin
        req_hit_c   = 1'b0;
        grant_idx_c = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!req_hit_c && req_valid[wrap_idx(SUM_W'(ptr_q) + SUM_W'(k))]) begin
                req_hit_c   = 1'b1;
                grant_idx_c = wrap_idx(SUM_W'(ptr_q) + SUM_W'(k));
            end
        end
        grant_c = req_hit_c && !fifo_full && !rst;
    end

    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_data_in = '0;
        ptr_d        = ptr_q;
        grant_id_d   = grant_id_q;
        if (grant_c) begin
            req_ready[grant_idx_c] = 1'b1;
            fifo_wr_en             = 1'b1;
            case (grant_idx_c)
                2'd0:    fifo_data_in = req_data[7:0];
                2'd1:    fifo_data_in = req_data[15:8];
                default: fifo_data_in = req_data[23:16];
            endcase
            ptr_d      = wrap_idx(SUM_W'(grant_idx_c) + SUM_W'(1));
            grant_id_d = grant_idx_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            grant_id_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign grant_id    = grant_id_q;
    assign almost_full = (32'(fifo_words) >= AFULL_LEVEL);

    // Read side: a read issued now returns data next cycle, so count it as reserved space.
    assign m_valid    = (state_q != ST_EMPTY);
    assign m_data     = head_q;
    assign pop_c      = m_valid && m_ready;
    assign capture_c  = inflight_q;
    assign pending_c  = SUM_W'(state_q) + SUM_W'(inflight_q) - SUM_W'(pop_c);
    assign fifo_rd_en = !rst && !fifo_empty && (pending_c < SUM_W'(2));
    assign inflight_d = fifo_rd_en;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            ST_EMPTY: begin
                if (capture_c) begin
                    head_d  = fifo_data_out;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (capture_c && pop_c) begin
                    head_d = fifo_data_out;
                end else if (capture_c) begin
                    tail_d  = fifo_data_out;
                    state_d = ST_TWO;
                end else if (pop_c) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (capture_c && pop_c) begin
                    head_d = tail_q;
                    tail_d = fifo_data_out;
                end else if (pop_c) begin
                    head_d  = tail_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
    a_rd_nonempty:  assert property (@(posedge clk) disable iff (rst) fifo_rd_en |-> !fifo_empty);
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst)
                                     !(capture_c && !pop_c && state_q == ST_TWO));

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scoreboard bench for fifo_ctrl with a behavioural FIFO that answers
// reads one cycle late; inputs change at posedge+2, outputs are sampled at negedge.
module tb_fifo_ctrl;

    localparam int unsigned AFULL = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_ready;
    logic        fifo_wr_en;
    logic [7:0]  fifo_data_in;
    logic        fifo_full;
    logic        fifo_rd_en;
    logic [7:0]  fifo_data_out;
    logic        fifo_empty;
    logic [3:0]  fifo_words;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;
    logic [1:0]  grant_id;
    logic        almost_full;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    logic       hold = 1'b0;
    int         m_ptr = 0;
    int         m_gid = 0;

    fifo_ctrl #(.AFULL_LEVEL(AFULL)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_data_out(fifo_data_out),
        .fifo_empty   (fifo_empty),
        .fifo_words   (fifo_words),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .grant_id     (grant_id),
        .almost_full  (almost_full)
    );

    always #5 clk = ~clk;

    // FIFO model: a read seen during a cycle returns its byte just after the next edge.
    initial begin : fifo_model
        logic rd_s;
        fifo_data_out = '0;
        fifo_empty    = 1'b1;
        fifo_words    = '0;
        forever begin
            @(negedge clk);
            rd_s = fifo_rd_en;
            @(posedge clk);
            #1;
            if (rd_s) begin
                checks++;
                if (fq.size() == 0) begin
                    errors++;
                    $display("FAIL fifo_underflow: fifo_rd_en=1 with FIFO empty, required 0");
                end else begin
                    fifo_data_out = fq.pop_front();
                end
            end
            fifo_words = 4'(fq.size());
            fifo_empty = hold || (fq.size() == 0);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int rr_pick(input int p, input logic [2:0] v);
        for (int k = 0; k < 3; k++) begin
            if (v[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 3'b111;
        req_data  = 24'h332211;
        fifo_full = 1'b0;
        m_ready   = 1'b1;
        fq.push_back(8'h5A);
        exp_q.push_back(8'h5A);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b000) begin errors++; $display("FAIL rst_req_ready: got %b required 000", req_ready); end
        checks++;
        if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b required 0", fifo_wr_en); end
        checks++;
        if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b required 0", fifo_rd_en); end
        checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00) begin
            errors++; $display("FAIL rst_stream: m_valid=%b m_data=%h required 0/00", m_valid, m_data);
        end
        checks++;
        if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id: got %0d required 0", grant_id); end
        @(posedge clk); #2;
        rst       = 1'b0;
        req_valid = 3'b000;
        m_ptr     = 0;
        m_gid     = 0;
        for (int cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) begin
            @(negedge clk);
            if (m_valid) begin
                checks++;
                if (m_data !== exp_q[0]) begin errors++; $display("FAIL rst_drain: m_data=%h required %h", m_data, exp_q[0]); end
                if (m_ready) void'(exp_q.pop_front());
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rst_drain_timeout: %0d bytes left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_round_robin();
        int g;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
            req_valid = 3'b111;
            req_data  = 24'($urandom);
            g = i % 3;
            @(negedge clk);
            checks++;
            if (req_ready !== 3'(1 << g)) begin errors++; $display("FAIL rr_ready[%0d]: got %b required %b", i, req_ready, 3'(1 << g)); end
            checks++;
            if (fifo_wr_en !== 1'b1 || fifo_data_in !== req_data[8*g +: 8]) begin
                errors++; $display("FAIL rr_data[%0d]: wr_en=%b data=%h required 1/%h", i, fifo_wr_en, fifo_data_in, req_data[8*g +: 8]);
            end
            checks++;
            if (grant_id !== 2'(m_gid)) begin errors++; $display("FAIL rr_grant_id[%0d]: got %0d required %0d", i, grant_id, m_gid); end
            m_gid = g;
            m_ptr = (g + 1) % 3;
        end
        @(posedge clk); #2;
        req_valid = 3'b000;
        @(negedge clk);
        checks++;
        if (grant_id !== 2'(m_gid) || req_ready !== 3'b000 || fifo_wr_en !== 1'b0) begin
            errors++; $display("FAIL rr_idle: grant_id=%0d ready=%b wr_en=%b required %0d/000/0", grant_id, req_ready, fifo_wr_en, m_gid);
        end
    endtask

    task automatic test_skip();
        logic [2:0] pats [8] = '{3'b001, 3'b101, 3'b101, 3'b000, 3'b010, 3'b110, 3'b100, 3'b011};
        logic [2:0] v;
        logic [2:0] er;
        int g;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            v         = (i < 8) ? pats[i] : 3'($urandom_range(0, 7));
            req_valid = v;
            req_data  = 24'($urandom);
            g  = rr_pick(m_ptr, v);
            er = (g < 0) ? 3'b000 : 3'(1 << g);
            @(negedge clk);
            checks++;
            if (req_ready !== er || fifo_wr_en !== (g >= 0)) begin
                errors++; $display("FAIL skip_ready[%0d]: valid=%b ready=%b wr_en=%b required %b", i, v, req_ready, fifo_wr_en, er);
            end
            if (g >= 0) begin
                checks++;
                if (fifo_data_in !== req_data[8*g +: 8]) begin errors++; $display("FAIL skip_data[%0d]: got %h required %h", i, fifo_data_in, req_data[8*g +: 8]); end
            end
            checks++;
            if (grant_id !== 2'(m_gid)) begin errors++; $display("FAIL skip_grant_id[%0d]: got %0d required %0d", i, grant_id, m_gid); end
            if (g >= 0) begin
                m_gid = g;
                m_ptr = (g + 1) % 3;
            end
        end
        @(posedge clk); #2;
        req_valid = 3'b000;
    endtask

    task automatic test_full();
        int g;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            fifo_full = 1'b1;
            req_valid = 3'b111;
            req_data  = 24'($urandom);
            @(negedge clk);
            checks++;
            if (req_ready !== 3'b000 || fifo_wr_en !== 1'b0) begin
                errors++; $display("FAIL full_block[%0d]: ready=%b wr_en=%b required 000/0", i, req_ready, fifo_wr_en);
            end
            checks++;
            if (grant_id !== 2'(m_gid)) begin errors++; $display("FAIL full_grant_id[%0d]: got %0d required %0d", i, grant_id, m_gid); end
        end
        @(posedge clk); #2;
        fifo_full = 1'b0;
        g = rr_pick(m_ptr, 3'b111);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'(1 << g)) begin errors++; $display("FAIL full_ptr_hold: ready=%b required %b", req_ready, 3'(1 << g)); end
        m_gid = g;
        m_ptr = (g + 1) % 3;
        @(posedge clk); #2;
        req_valid = 3'b000;
    endtask

    task automatic test_almost_full();
        int sizes [5] = '{0, 5, 6, 9, 15};
        @(posedge clk); #2;
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            fq.delete();
            for (int k = 0; k < sizes[i]; k++) fq.push_back(8'(k));
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (almost_full !== (sizes[i] >= AFULL)) begin
                errors++; $display("FAIL almost_full[%0d]: words=%0d got %b required %b", i, sizes[i], almost_full, sizes[i] >= AFULL);
            end
        end
        @(posedge clk); #2;
        fq.delete();
        hold = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_stream_latency();
        int first_rd;
        int first_mv;
        int last_mv;
        int n_mv;
        first_rd = -1;
        first_mv = -1;
        last_mv  = -1;
        n_mv     = 0;
        @(posedge clk); #2;
        m_ready = 1'b1;
        fq.push_back(8'hA1); fq.push_back(8'hA2); fq.push_back(8'hA3);
        exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
        for (int cyc = 0; cyc < 30 && exp_q.size() != 0; cyc++) begin
            @(negedge clk);
            if (fifo_rd_en && first_rd < 0) first_rd = cyc;
            if (m_valid) begin
                if (first_mv < 0) first_mv = cyc;
                last_mv = cyc;
                n_mv++;
                checks++;
                if (m_data !== exp_q[0]) begin errors++; $display("FAIL stream_data: got %h required %h", m_data, exp_q[0]); end
                if (m_ready) void'(exp_q.pop_front());
            end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL stream_timeout: %0d bytes left, required 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (first_rd < 0 || first_mv - first_rd != 2) begin
            errors++; $display("FAIL stream_latency: rd at %0d, valid at %0d, required gap 2", first_rd, first_mv);
        end
        checks++;
        if (n_mv != 3 || last_mv - first_mv != 2) begin
            errors++; $display("FAIL stream_rate: %0d valid cycles over span %0d, required 3 over 2", n_mv, last_mv - first_mv);
        end
    endtask

    task automatic test_backpressure();
        @(posedge clk); #2;
        m_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            fq.push_back(8'hB1 + 8'(k));
            exp_q.push_back(8'hB1 + 8'(k));
        end
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (m_valid) begin
                checks++;
                if (m_data !== exp_q[0]) begin errors++; $display("FAIL bp_hold[%0d]: got %h required %h", cyc, m_data, exp_q[0]); end
            end
        end
        checks++;
        if (m_valid !== 1'b1 || fifo_rd_en !== 1'b0) begin
            errors++; $display("FAIL bp_stall: m_valid=%b rd_en=%b required 1/0", m_valid, fifo_rd_en);
        end
        checks++;
        if (fq.size() != 2) begin errors++; $display("FAIL bp_reads: %0d bytes left in FIFO, required 2", fq.size()); end
        @(posedge clk); #2;
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && exp_q.size() != 0; cyc++) begin
            @(negedge clk);
            if (m_valid) begin
                checks++;
                if (m_data !== exp_q[0]) begin errors++; $display("FAIL bp_drain: got %h required %h", m_data, exp_q[0]); end
                if (m_ready) void'(exp_q.pop_front());
            end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bp_timeout: %0d bytes left, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        logic [2:0] v;
        logic [2:0] er;
        int g;
        @(posedge clk); #2;
        for (int k = 0; k < 16; k++) begin
            b = 8'($urandom);
            fq.push_back(b);
            exp_q.push_back(b);
        end
        for (int cyc = 0; cyc < 300 && exp_q.size() != 0; cyc++) begin
            @(posedge clk); #2;
            m_ready   = ($urandom_range(0, 3) != 0);
            fifo_full = ($urandom_range(0, 4) == 0);
            v         = 3'($urandom_range(0, 7));
            req_valid = v;
            req_data  = 24'($urandom);
            g  = fifo_full ? -1 : rr_pick(m_ptr, v);
            er = (g < 0) ? 3'b000 : 3'(1 << g);
            @(negedge clk);
            if (m_valid) begin
                checks++;
                if (m_data !== exp_q[0]) begin errors++; $display("FAIL b2b_data[%0d]: got %h required %h", cyc, m_data, exp_q[0]); end
                if (m_ready) void'(exp_q.pop_front());
            end
            checks++;
            if (req_ready !== er || grant_id !== 2'(m_gid)) begin
                errors++; $display("FAIL b2b_arb[%0d]: ready=%b grant_id=%0d required %b/%0d", cyc, req_ready, grant_id, er, m_gid);
            end
            if (g >= 0) begin
                m_gid = g;
                m_ptr = (g + 1) % 3;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_timeout: %0d bytes left, required 0", exp_q.size()); exp_q.delete(); end
        @(posedge clk); #2;
        req_valid = 3'b000;
        fifo_full = 1'b0;
        m_ready   = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset_midstream();
        @(posedge clk); #2;
        req_valid = 3'b001;
        req_data  = 24'($urandom);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin errors++; $display("FAIL mid_pre_grant: got %b required 001", req_ready); end
        m_gid = 0;
        m_ptr = 1;
        @(posedge clk); #2;
        req_valid = 3'b000;
        m_ready   = 1'b0;
        fq.push_back(8'hC1); fq.push_back(8'hC2); fq.push_back(8'hC3);
        exp_q.push_back(8'hC1); exp_q.push_back(8'hC2); exp_q.push_back(8'hC3);
        repeat (6) @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || fifo_rd_en !== 1'b0 || fq.size() != 1) begin
            errors++; $display("FAIL mid_full_buf: m_valid=%b rd_en=%b fifo_left=%0d required 1/0/1", m_valid, fifo_rd_en, fq.size());
        end
        @(posedge clk); #2;
        rst       = 1'b1;
        req_valid = 3'b111;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00) begin
            errors++; $display("FAIL mid_rst_stream: m_valid=%b m_data=%h required 0/00", m_valid, m_data);
        end
        checks++;
        if (fifo_rd_en !== 1'b0 || req_ready !== 3'b000) begin
            errors++; $display("FAIL mid_rst_ctl: rd_en=%b ready=%b required 0/000", fifo_rd_en, req_ready);
        end
        while (exp_q.size() > fq.size()) void'(exp_q.pop_front());
        repeat (2) @(posedge clk);
        #2;
        rst     = 1'b0;
        m_ready = 1'b1;
        m_ptr   = 0;
        m_gid   = 0;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001 || fifo_wr_en !== 1'b1 || grant_id !== 2'd0) begin
            errors++; $display("FAIL mid_post_grant: ready=%b wr_en=%b grant_id=%0d required 001/1/0", req_ready, fifo_wr_en, grant_id);
        end
        m_ptr = 1;
        @(posedge clk); #2;
        req_valid = 3'b000;
        for (int cyc = 0; cyc < 30 && exp_q.size() != 0; cyc++) begin
            @(negedge clk);
            if (m_valid) begin
                checks++;
                if (m_data !== exp_q[0]) begin errors++; $display("FAIL mid_resume: got %h required %h", m_data, exp_q[0]); end
                if (m_ready) void'(exp_q.pop_front());
            end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL mid_timeout: %0d bytes left, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin : main
        rst       = 1'b1;
        req_valid = 3'b000;
        req_data  = '0;
        fifo_full = 1'b0;
        m_ready   = 1'b0;
        test_reset();
        test_round_robin();
        test_skip();
        test_full();
        test_almost_full();
        test_stream_latency();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 The block SHALL have parameter AFULL_LEVEL, default 6, meaning the fifo_words threshold at or above which almost_full asserts.
REQ-002 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  is the asynchronous, active-high reset.
REQ-004 Port req_valid  input  3  is the per-requester write-request valid; bit i belongs to requester i.
REQ-005 Port req_data  input  24  is the requester i byte at bits [8i+7:8i].
REQ-006 Port req_ready  output  3  is the per-requester accept strobe, at most one bit high.
REQ-007 Port fifo_wr_en  output  1  drives the FIFO write enable.
REQ-008 Port fifo_data_in  output  8  drives the FIFO write data.
REQ-009 Port fifo_full  input  1  is the FIFO full flag.
REQ-010 Port fifo_rd_en  output  1  drives the FIFO read enable.
REQ-011 Port fifo_data_out  input  8  is the FIFO read data, valid on the cycle after an accepted read.
REQ-012 Port fifo_empty  input  1  is the FIFO empty flag.
REQ-013 Port fifo_words  input  4  is the FIFO occupancy.
REQ-014 Port m_valid / m_data / m_ready  output 1 / output 8 / input 1  form the consumer stream; a transfer occurs when m_valid and m_ready are both high.
REQ-015 Port grant_id  output  2  is the index of the last granted requester (registered).
REQ-016 Port almost_full  output  1  is high when fifo_words >= AFULL_LEVEL (combinational).

Function
REQ-017 Write arbitration SHALL be combinational round-robin over requesters 0..2, searching upward from a 2-bit priority pointer ptr, modulo 3.
REQ-018 The grant SHALL be issued only when fifo_full=0 and rst=0; with fifo_full=1, req_ready=000 and fifo_wr_en=0.
REQ-019 On a grant to g: req_ready[g]=1, fifo_wr_en=1, fifo_data_in=req_data slice g, all in the same cycle (zero latency).
REQ-020 After a grant to g, ptr SHALL become (g+1) mod 3 and grant_id SHALL become g; with no grant, both hold.
REQ-021 Requesters whose req_valid is low SHALL be skipped without consuming a turn.
REQ-022 The read side SHALL hold a 2-entry output buffer with occupancy occ in {0,1,2} (states EMPTY, ONE, TWO) plus a one-bit inflight flag.
REQ-023 fifo_rd_en SHALL be high when fifo_empty=0 and (occ + inflight - pop) < 2, where pop = m_valid & m_ready.
REQ-024 inflight SHALL be set on the cycle after fifo_rd_en=1 and cleared otherwise; when inflight=1, fifo_data_out SHALL be written into the buffer tail.
REQ-025 m_valid SHALL equal (occ != 0), and m_data SHALL be the buffer head.
REQ-026 Occupancy transitions:
- simultaneous capture and pop keeps occ unchanged;
- capture only: occ+1;
- pop only: occ-1.
REQ-027 Order SHALL be preserved: the stream bytes leave in FIFO read order.
REQ-028 m_data SHALL stay stable while m_valid=1 and m_ready=0.
REQ-029 With a continuously nonempty FIFO and m_ready=1, throughput SHALL be one byte per cycle after a 2-cycle initial latency from fifo_rd_en to m_valid.

Reset
REQ-030 While rst=1: ptr=0, grant_id=0, occ=0, inflight=0, m_valid=0, m_data=0, req_ready=000, fifo_wr_en=0, fifo_rd_en=0.
REQ-031 Reset asserted mid-operation SHALL discard buffered and in-flight read data; the first write grant after rst deasserts goes to the lowest-index valid requester.

Verification
REQ-032 Bench: all three req_valid=1, fifo_full=0 for 6 cycles -> grants 0,1,2,0,1,2 and grant_id follows one cycle later.
REQ-033 Bench: req_valid=101, ptr=1 -> grant 2, then 0.
REQ-034 Bench: fifo_full=1 with req_valid=111 -> req_ready=000, fifo_wr_en=0, ptr unchanged.
REQ-035 Bench: FIFO holds 0xA1,0xA2,0xA3; m_ready=1 -> m_data A1,A2,A3 on consecutive cycles, first 2 cycles after the first fifo_rd_en.
REQ-036 Bench: m_ready=0 for 5 cycles with the FIFO nonempty -> occ reaches 2, fifo_rd_en stops, and m_data is held.
REQ-037 Bench: rst pulse while occ=2 -> m_valid=0 immediately, fifo_rd_en=0, and normal operation resumes after release.
